// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and buffered load returns onto the
// integer register file's single registered write port and reports pending writes.
module wb_arbiter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_we,
  output logic [AW-1:0]   rf_addr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  wb_entry_t           fifo_mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       count;
  logic                full;
  logic                empty;
  logic                drain;
  logic                take_alu;
  logic                enq;
  wb_entry_t           head;
  logic [DEPTH-1:0]    slot_valid;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  assign count = wr_ptr - rd_ptr;
  assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = fifo_mem[rd_ptr[IW-1:0]];

  assign ld_ready  = !full;
  assign alu_ready = !full;

  // Write-port arbitration: a full FIFO preempts the ALU for one drain
  always_comb begin
    drain    = 1'b0;
    take_alu = 1'b0;
    if (full) begin
      drain = 1'b1;
    end else if (alu_valid && (alu_rd != '0)) begin
      take_alu = 1'b1;
    end else if (!empty) begin
      drain = 1'b1;
    end
    enq = ld_valid && !full && (ld_rd != '0);
  end

  // A physical slot is live when its distance from the read index is below count
  always_comb begin
    logic [IW-1:0] off;
    off        = '0;
    slot_valid = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      off           = IW'(j) - rd_ptr[IW-1:0];
      slot_valid[j] = (PW'(off) < count);
    end
  end

  always_comb begin
    rs1_busy = rf_we && (rf_addr == rs1);
    rs2_busy = rf_we && (rf_addr == rs2);
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (slot_valid[j] && (fifo_mem[j].rd == rs1)) rs1_busy = 1'b1;
      if (slot_valid[j] && (fifo_mem[j].rd == rs2)) rs2_busy = 1'b1;
    end
    if (rs1 == '0) rs1_busy = 1'b0;
    if (rs2 == '0) rs2_busy = 1'b0;
  end

  // Storage needs no reset: liveness is defined by the pointers alone
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_mem[wr_ptr[IW-1:0]] <= '{rd: ld_rd, data: ld_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else begin
      if (enq)   wr_ptr <= wr_ptr + PW'(1);
      if (drain) rd_ptr <= rd_ptr + PW'(1);
      rf_we <= drain || take_alu;
      if (take_alu) begin
        rf_addr  <= alu_rd;
        rf_wdata <= alu_data;
      end else if (drain) begin
        rf_addr  <= head.rd;
        rf_wdata <= head.data;
      end
    end
  end

endmodule
